// File: rtl/tile_pixel_pipe_pkg.sv
// Shared definitions for the tile pixel pipeline: default geometry, RGB332 layout, colour key.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tile_pixel_pipe_pkg;

   localparam int CNT_W_DEF      = 10;
   localparam int TILE_SHIFT_DEF = 4;
   localparam int NUM_TILES_DEF  = 16;
   localparam int MAP_COLS_DEF   = 40;
   localparam int MAP_ROWS_DEF   = 30;
   localparam int HLEFT_DEF      = 144;
   localparam int VTOP_DEF       = 31;

   localparam logic [7:0] KEY_COLOR_DEF = 8'hFF;

   // RGB332 byte: blue in the top two bits, red in the bottom three
   localparam int R_LSB = 0;
   localparam int G_LSB = 3;
   localparam int B_LSB = 6;

   typedef struct packed {
      logic [1:0] b;
      logic [2:0] g;
      logic [2:0] r;
   } rgb332_t;

   function automatic rgb332_t to_rgb(input logic [7:0] d);
      return rgb332_t'(d);
   endfunction

endpackage

// File: rtl/tile_pixel_pipe_if.sv
// Bundle of video timing inputs, RAM write ports, style controls and DAC outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are free-running.
interface tile_pixel_pipe_if
   import tile_pixel_pipe_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int TILE_SHIFT = TILE_SHIFT_DEF,
   parameter int NUM_TILES  = NUM_TILES_DEF,
   parameter int MAP_COLS   = MAP_COLS_DEF,
   parameter int MAP_ROWS   = MAP_ROWS_DEF
);
   localparam int MAP_AW = $clog2(MAP_COLS * MAP_ROWS);
   localparam int IDX_W  = $clog2(NUM_TILES);
   localparam int PIX_AW = IDX_W + 2 * TILE_SHIFT;

   logic [CNT_W-1:0]  hcount;
   logic [CNT_W-1:0]  vcount;
   logic              bright;
   logic              hsync;
   logic              vsync;
   logic              map_we;
   logic [MAP_AW-1:0] map_waddr;
   logic [IDX_W-1:0]  map_wdata;
   logic              tile_we;
   logic [PIX_AW-1:0] tile_waddr;
   logic [7:0]        tile_wdata;
   logic              key_en;
   logic [7:0]        bg_color;
   logic [2:0]        R;
   logic [2:0]        G;
   logic [1:0]        B;
   logic              bright_o;
   logic              hsync_o;
   logic              vsync_o;

   modport master (
      output hcount, vcount, bright, hsync, vsync,
      output map_we, map_waddr, map_wdata, tile_we, tile_waddr, tile_wdata,
      output key_en, bg_color,
      input  R, G, B, bright_o, hsync_o, vsync_o
   );

   modport slave (
      input  hcount, vcount, bright, hsync, vsync,
      input  map_we, map_waddr, map_wdata, tile_we, tile_waddr, tile_wdata,
      input  key_en, bg_color,
      output R, G, B, bright_o, hsync_o, vsync_o
   );

endinterface

// File: rtl/tile_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first on collision.
// Latency: 1 clk from raddr to rdata.
// Backpressure: none; writes to addresses >= DEPTH are dropped.
module tile_dp_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Read and write in one block: the read sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (we && (int'(waddr) < DEPTH)) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/tile_pixel_pipe.sv
// Tile renderer: screen position -> tile map -> tile pixel store -> RGB332 with colour key.
// Latency: fixed 3 clk from hcount/vcount/bright/syncs to R/G/B and *_o.
// Backpressure: none; never stalls, RAM writes accepted every cycle.
// Ports: clk/rst (sync, active high) plus vif (slave): timing in, map/tile write ports,
//        key_en/bg_color, R/G/B and delayed bright/hsync/vsync out.
module tile_pixel_pipe
   import tile_pixel_pipe_pkg::*;
#(
   parameter int         CNT_W      = CNT_W_DEF,
   parameter int         TILE_SHIFT = TILE_SHIFT_DEF,
   parameter int         NUM_TILES  = NUM_TILES_DEF,
   parameter int         MAP_COLS   = MAP_COLS_DEF,
   parameter int         MAP_ROWS   = MAP_ROWS_DEF,
   parameter int         HLEFT      = HLEFT_DEF,
   parameter int         VTOP       = VTOP_DEF,
   parameter logic [7:0] KEY_COLOR  = KEY_COLOR_DEF
) (
   input logic         clk,
   input logic         rst,
   tile_pixel_pipe_if.slave vif
);

   localparam int MAP_DEPTH = MAP_COLS * MAP_ROWS;
   localparam int MAP_AW    = $clog2(MAP_DEPTH);
   localparam int IDX_W     = $clog2(NUM_TILES);
   localparam int PIX_AW    = IDX_W + 2 * TILE_SHIFT;
   localparam int CR_W      = CNT_W - TILE_SHIFT;

   localparam logic [CNT_W-1:0] XOFF = CNT_W'(HLEFT + 1);
   localparam logic [CNT_W-1:0] YOFF = CNT_W'(VTOP + 1);

   // Screen position relative to the first active pixel; wraps in blanking.
   logic [CNT_W-1:0]  x, y;
   logic [CR_W-1:0]   col, row;
   logic [MAP_AW-1:0] maddr;
   logic              in_map;

   assign x   = vif.hcount - XOFF;
   assign y   = vif.vcount - YOFF;
   assign col = x[CNT_W-1:TILE_SHIFT];
   assign row = y[CNT_W-1:TILE_SHIFT];
   // Truncation only corrupts addresses outside the map, which in_map masks.
   assign maddr  = MAP_AW'(row) * MAP_AW'(MAP_COLS) + MAP_AW'(col);
   assign in_map = (int'(col) < MAP_COLS) && (int'(row) < MAP_ROWS);

   // Stage 1
   logic [MAP_AW-1:0]     s1_maddr;
   logic [TILE_SHIFT-1:0] s1_px, s1_py;
   logic [7:0]            s1_bg;
   logic s1_bright, s1_in_map, s1_key, s1_hs, s1_vs;
   // Stage 2
   logic [TILE_SHIFT-1:0] s2_px, s2_py;
   logic [7:0]            s2_bg;
   logic s2_bright, s2_in_map, s2_key, s2_hs, s2_vs;
   // Stage 3
   logic [7:0]            s3_bg;
   logic s3_bright, s3_in_map, s3_key, s3_hs, s3_vs;

   logic [IDX_W-1:0]  map_idx;
   logic [PIX_AW-1:0] pix_raddr;
   logic [7:0]        pix;
   logic [7:0]        out_pix;
   rgb332_t           rgb;

   // Control flags: cleared by reset so outputs go dark on the next edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         {s1_bright, s1_in_map, s1_key, s1_hs, s1_vs} <= '0;
         {s2_bright, s2_in_map, s2_key, s2_hs, s2_vs} <= '0;
         {s3_bright, s3_in_map, s3_key, s3_hs, s3_vs} <= '0;
      end else begin
         s1_bright <= vif.bright;
         s1_in_map <= in_map;
         s1_key    <= vif.key_en;
         s1_hs     <= vif.hsync;
         s1_vs     <= vif.vsync;
         {s2_bright, s2_in_map, s2_key, s2_hs, s2_vs} <=
            {s1_bright, s1_in_map, s1_key, s1_hs, s1_vs};
         {s3_bright, s3_in_map, s3_key, s3_hs, s3_vs} <=
            {s2_bright, s2_in_map, s2_key, s2_hs, s2_vs};
      end
   end

   // Datapath registers: meaningless while the flags are clear, so no reset.
   always_ff @(posedge clk) begin
      s1_maddr <= maddr;
      s1_px    <= x[TILE_SHIFT-1:0];
      s1_py    <= y[TILE_SHIFT-1:0];
      s1_bg    <= vif.bg_color;
      s2_px    <= s1_px;
      s2_py    <= s1_py;
      s2_bg    <= s1_bg;
      s3_bg    <= s2_bg;
   end

   tile_dp_ram #(.DEPTH(MAP_DEPTH), .WIDTH(IDX_W)) u_map_ram (
      .clk   (clk),
      .we    (vif.map_we),
      .waddr (vif.map_waddr),
      .wdata (vif.map_wdata),
      .raddr (s1_maddr),
      .rdata (map_idx)
   );

   // Tile index arrives straight from the map RAM register, so the pixel
   // address is formed combinationally to keep the pipe at three stages.
   assign pix_raddr = {map_idx, s2_py, s2_px};

   tile_dp_ram #(.DEPTH(NUM_TILES << (2 * TILE_SHIFT)), .WIDTH(8)) u_pix_ram (
      .clk   (clk),
      .we    (vif.tile_we),
      .waddr (vif.tile_waddr),
      .wdata (vif.tile_wdata),
      .raddr (pix_raddr),
      .rdata (pix)
   );

   always_comb begin
      out_pix = '0;
      if (!s3_bright) begin
         out_pix = '0;
      end else if (!s3_in_map) begin
         out_pix = s3_bg;
      end else if (s3_key && (pix == KEY_COLOR)) begin
         out_pix = s3_bg;
      end else begin
         out_pix = pix;
      end
   end

   assign rgb          = to_rgb(out_pix);
   assign vif.R        = rgb.r;
   assign vif.G        = rgb.g;
   assign vif.B        = rgb.b;
   assign vif.bright_o = s3_bright;
   assign vif.hsync_o  = s3_hs;
   assign vif.vsync_o  = s3_vs;

endmodule
